// File: rtl/axi4m_rd_arb.sv
// ---------------------------------------------------------------------------
// axi4m_rd_arb
//
// Shares one AXI4 read channel (AR + R) of a DDR controller among up to four
// read requesters.
//   AR path: round-robin grant among eligible requesters. The granted command
//            is registered toward DDR with the requester index placed in
//            m_arid[3:2].
//   R path : combinational routing of returned beats by m_rid[3:2].
//   Per-requester outstanding-burst counters cap each requester at OST_MAX.
//
// Ports
//   clk_sys, rst             clock, synchronous active-high reset
//   s_ar*                    requester AR channels, packed per requester
//   s_r*                     requester R channels (data fanned out, valid routed)
//   m_ar*, m_r*              DDR-side AXI4 read channel
//   reg_arb_en               1 = new grants allowed
//   cnt_reg_clr              clears reg_rsp_err
//   reg_ost_cnt              packed outstanding counters, requester 0 in the LSBs
//   reg_rsp_err              sticky: bad RID index, or burst end with zero outstanding
// ---------------------------------------------------------------------------
module axi4m_rd_arb #(
   parameter int REQ_NUM = 2,
   parameter int OST_MAX = 16,
   parameter int OST_WTH = 5
) (
   input  logic                         clk_sys,
   input  logic                         rst,
   input  logic [2*REQ_NUM-1:0]         s_arid,
   input  logic [64*REQ_NUM-1:0]        s_araddr,
   input  logic [8*REQ_NUM-1:0]         s_arlen,
   input  logic [3*REQ_NUM-1:0]         s_arsize,
   input  logic [REQ_NUM-1:0]           s_arvalid,
   output logic [REQ_NUM-1:0]           s_arready,
   output logic [2*REQ_NUM-1:0]         s_rid,
   output logic [512*REQ_NUM-1:0]       s_rdata,
   output logic [2*REQ_NUM-1:0]         s_rresp,
   output logic [REQ_NUM-1:0]           s_rlast,
   output logic [REQ_NUM-1:0]           s_rvalid,
   input  logic [REQ_NUM-1:0]           s_rready,
   output logic [3:0]                   m_arid,
   output logic [63:0]                  m_araddr,
   output logic [7:0]                   m_arlen,
   output logic [2:0]                   m_arsize,
   output logic                         m_arvalid,
   input  logic                         m_arready,
   input  logic [3:0]                   m_rid,
   input  logic [511:0]                 m_rdata,
   input  logic [1:0]                   m_rresp,
   input  logic                         m_rlast,
   input  logic                         m_rvalid,
   output logic                         m_rready,
   input  logic                         reg_arb_en,
   input  logic                         cnt_reg_clr,
   output logic [OST_WTH*REQ_NUM-1:0]   reg_ost_cnt,
   output logic                         reg_rsp_err
);

   localparam logic [OST_WTH-1:0] OST_LIM = OST_WTH'(OST_MAX);

   logic [OST_WTH-1:0] ost_cnt [REQ_NUM];
   logic [1:0]         rr_ptr;
   logic [REQ_NUM-1:0] elig;
   logic [REQ_NUM-1:0] ar_hs;
   logic [REQ_NUM-1:0] r_match;
   logic [REQ_NUM-1:0] r_done;
   logic [REQ_NUM-1:0] dec_at_zero;
   logic               load;
   logic               found;
   logic               grant;
   logic [1:0]         sel;
   logic               r_idx_ok;
   logic               rsp_err_set;

   // A simultaneous issue and burst completion cancel out. Completion with no
   // outstanding burst leaves the counter at zero and is flagged separately.
   function automatic logic [OST_WTH-1:0] ost_next(input logic [OST_WTH-1:0] cnt,
                                                   input logic inc,
                                                   input logic dec);
      if (inc && !dec) return cnt + OST_WTH'(1);
      if (dec && !inc && cnt != '0) return cnt - OST_WTH'(1);
      return cnt;
   endfunction

   // ---- AR grant (combinational, same cycle as requester handshake) ----
   always_comb begin
      elig = '0;
      for (int k = 0; k < REQ_NUM; k++)
         elig[k] = s_arvalid[k] && (ost_cnt[k] < OST_LIM);
   end

   always_comb begin
      found = 1'b0;
      sel   = 2'd0;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (!found && elig[(int'(rr_ptr) + i) % REQ_NUM]) begin
            found = 1'b1;
            sel   = 2'((int'(rr_ptr) + i) % REQ_NUM);
         end
      end
   end

   // The output register may only load when empty or draining this cycle.
   assign load      = !rst && reg_arb_en && (!m_arvalid || m_arready);
   assign grant     = load && found;
   assign s_arready = grant ? (REQ_NUM'(1) << sel) : '0;
   assign ar_hs     = s_arvalid & s_arready;

   // ---- R routing (combinational, no added latency) ----
   always_comb begin
      r_match  = '0;
      s_rvalid = '0;
      m_rready = 1'b0;
      for (int k = 0; k < REQ_NUM; k++)
         r_match[k] = (m_rid[3:2] == 2'(k));
      if (!rst) begin
         for (int k = 0; k < REQ_NUM; k++) begin
            if (r_match[k]) begin
               s_rvalid[k] = m_rvalid;
               m_rready    = s_rready[k];
            end
         end
         // Beats tagged for a requester that does not exist are swallowed.
         if (!r_idx_ok)
            m_rready = 1'b1;
      end
   end

   assign r_idx_ok = |r_match;
   assign s_rid    = {REQ_NUM{m_rid[1:0]}};
   assign s_rdata  = {REQ_NUM{m_rdata}};
   assign s_rresp  = {REQ_NUM{m_rresp}};
   assign s_rlast  = {REQ_NUM{m_rlast}};

   always_comb begin
      r_done      = '0;
      dec_at_zero = '0;
      reg_ost_cnt = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         r_done[k]      = m_rvalid && m_rready && m_rlast && r_match[k];
         dec_at_zero[k] = r_done[k] && !ar_hs[k] && (ost_cnt[k] == '0);
         reg_ost_cnt[k*OST_WTH +: OST_WTH] = ost_cnt[k];
      end
   end

   assign rsp_err_set = (m_rvalid && !r_idx_ok) || (|dec_at_zero);

   // ---- AR output register, counters, sticky error ----
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         m_arvalid   <= 1'b0;
         m_arid      <= '0;
         m_araddr    <= '0;
         m_arlen     <= '0;
         m_arsize    <= '0;
         rr_ptr      <= 2'd0;
         reg_rsp_err <= 1'b0;
         for (int k = 0; k < REQ_NUM; k++)
            ost_cnt[k] <= '0;
      end else begin
         if (grant) begin
            m_arvalid <= 1'b1;
            m_arid    <= {sel, s_arid[int'(sel)*2 +: 2]};
            m_araddr  <= s_araddr[int'(sel)*64 +: 64];
            m_arlen   <= s_arlen[int'(sel)*8 +: 8];
            m_arsize  <= s_arsize[int'(sel)*3 +: 3];
            rr_ptr    <= (int'(sel) == REQ_NUM - 1) ? 2'd0 : sel + 2'd1;
         end else if (m_arready) begin
            m_arvalid <= 1'b0;
         end

         for (int k = 0; k < REQ_NUM; k++)
            ost_cnt[k] <= ost_next(ost_cnt[k], ar_hs[k], r_done[k]);

         // A set wins over a clear in the same cycle.
         if (rsp_err_set)
            reg_rsp_err <= 1'b1;
         else if (cnt_reg_clr)
            reg_rsp_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4m_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_axi4m_rd_arb
//
// Directed bench for axi4m_rd_arb with three requesters: a table of R-routing
// vectors followed by hand-written sequences for grant order, outstanding
// limit, backpressure, bad RID handling, sticky error and reset mid-burst.
// ---------------------------------------------------------------------------
module tb_axi4m_rd_arb;

   localparam int N = 3;
   localparam int W = 5;

   logic               clk_sys;
   logic               rst;
   logic [2*N-1:0]     s_arid;
   logic [64*N-1:0]    s_araddr;
   logic [8*N-1:0]     s_arlen;
   logic [3*N-1:0]     s_arsize;
   logic [N-1:0]       s_arvalid;
   logic [N-1:0]       s_arready;
   logic [2*N-1:0]     s_rid;
   logic [512*N-1:0]   s_rdata;
   logic [2*N-1:0]     s_rresp;
   logic [N-1:0]       s_rlast;
   logic [N-1:0]       s_rvalid;
   logic [N-1:0]       s_rready;
   logic [3:0]         m_arid;
   logic [63:0]        m_araddr;
   logic [7:0]         m_arlen;
   logic [2:0]         m_arsize;
   logic               m_arvalid;
   logic               m_arready;
   logic [3:0]         m_rid;
   logic [511:0]       m_rdata;
   logic [1:0]         m_rresp;
   logic               m_rlast;
   logic               m_rvalid;
   logic               m_rready;
   logic               reg_arb_en;
   logic               cnt_reg_clr;
   logic [W*N-1:0]     reg_ost_cnt;
   logic               reg_rsp_err;

   int n_run  = 0;
   int n_fail = 0;

   axi4m_rd_arb #(.REQ_NUM(N), .OST_MAX(16), .OST_WTH(W)) u_dut (
      .clk_sys(clk_sys), .rst(rst),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .reg_arb_en(reg_arb_en), .cnt_reg_clr(cnt_reg_clr),
      .reg_ost_cnt(reg_ost_cnt), .reg_rsp_err(reg_rsp_err)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [3:0]   rid;
      logic         rvalid;
      logic [N-1:0] rready;
      logic [N-1:0] exp_svalid;
      logic         exp_mready;
   } rvec_t;

   rvec_t vec [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle();
      s_arvalid   = '0;
      m_rvalid    = 1'b0;
      m_rlast     = 1'b0;
      s_rready    = '0;
      cnt_reg_clr = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_ar(input int k, input logic [1:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [2:0] size);
      s_arid[k*2 +: 2]    = id;
      s_araddr[k*64 +: 64] = addr;
      s_arlen[k*8 +: 8]   = len;
      s_arsize[k*3 +: 3]  = size;
   endtask

   function automatic logic [W-1:0] cnt(input int k);
      return reg_ost_cnt[k*W +: W];
   endfunction

   initial begin
      logic [1:0] e;

      vec[0] = '{4'h1, 1'b1, 3'b111, 3'b001, 1'b1};
      vec[1] = '{4'h1, 1'b1, 3'b110, 3'b001, 1'b0};
      vec[2] = '{4'h5, 1'b1, 3'b010, 3'b010, 1'b1};
      vec[3] = '{4'h6, 1'b1, 3'b101, 3'b010, 1'b0};
      vec[4] = '{4'hA, 1'b1, 3'b100, 3'b100, 1'b1};
      vec[5] = '{4'h9, 1'b0, 3'b100, 3'b000, 1'b1};
      vec[6] = '{4'h8, 1'b1, 3'b011, 3'b100, 1'b0};
      vec[7] = '{4'hD, 1'b0, 3'b000, 3'b000, 1'b1};

      rst = 1'b1; reg_arb_en = 1'b1; cnt_reg_clr = 1'b0;
      s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arvalid = '0;
      s_rready = '0; m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
      m_rlast = 1'b0; m_rvalid = 1'b0;
      tick(); tick();

      // Reset: outputs gated, registers cleared
      s_arvalid = '1; m_rvalid = 1'b1; s_rready = '1; #1;
      chk("rst_s_arready", s_arready, 0);
      chk("rst_s_rvalid", s_rvalid, 0);
      chk("rst_m_rready", m_rready, 0);
      tick();
      chk("rst_m_arvalid", m_arvalid, 0);
      chk("rst_m_arid", m_arid, 0);
      chk("rst_ost", reg_ost_cnt, 0);
      chk("rst_err", reg_rsp_err, 0);
      idle(); rst = 1'b0; tick();

      // R routing table
      m_rdata = {8{64'hDEAD_BEEF_0123_4567}};
      m_rresp = 2'b10;
      for (int i = 0; i < 8; i++) begin
         m_rid = vec[i].rid; m_rvalid = vec[i].rvalid; s_rready = vec[i].rready; #1;
         chk("tbl_s_rvalid", s_rvalid, vec[i].exp_svalid);
         chk("tbl_m_rready", m_rready, vec[i].exp_mready);
         chk("tbl_s_rid", s_rid, {N{vec[i].rid[1:0]}});
         tick();
      end
      chk("tbl_s_rdata2", s_rdata[1535:1024], {8{64'hDEAD_BEEF_0123_4567}});
      chk("tbl_s_rresp", s_rresp, 6'b101010);
      chk("tbl_err", reg_rsp_err, 0);
      chk("tbl_ost", reg_ost_cnt, 0);
      idle();

      // 1: single burst from requester 0
      set_ar(0, 2'b01, 64'h1000, 8'd7, 3'd6);
      s_arvalid = 3'b001; m_arready = 1'b1; #1;
      chk("t1_s_arready", s_arready, 3'b001);
      tick();
      s_arvalid = '0;
      chk("t1_m_arvalid", m_arvalid, 1);
      chk("t1_m_arid", m_arid, 4'h1);
      chk("t1_m_araddr", m_araddr, 64'h1000);
      chk("t1_m_arlen", m_arlen, 7);
      chk("t1_m_arsize", m_arsize, 6);
      chk("t1_ost0", cnt(0), 1);
      m_rid = 4'h1; m_rvalid = 1'b1; s_rready = 3'b011;
      for (int b = 0; b < 8; b++) begin
         m_rlast = (b == 7); #1;
         chk("t1_beat_s_rvalid", s_rvalid, 3'b001);
         chk("t1_beat_m_rready", m_rready, 1);
         tick();
      end
      idle();
      chk("t1_ost0_done", cnt(0), 0);
      chk("t1_m_arvalid_drop", m_arvalid, 0);

      // 2: round robin with all requesters pending
      do_reset();
      for (int k = 0; k < N; k++) set_ar(k, 2'(k), 64'(k) << 8, 8'd1, 3'd6);
      s_arvalid = '1; m_arready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         e = 2'(i % N); #1;
         chk("t2_s_arready", s_arready, 64'd1 << e);
         tick();
         chk("t2_m_arid", m_arid, {e, e});
         chk("t2_m_arvalid", m_arvalid, 1);
      end
      chk("t2_ost", reg_ost_cnt, {5'd2, 5'd2, 5'd2});
      idle(); tick();

      // 3: outstanding limit on requester 1
      do_reset();
      set_ar(1, 2'b11, 64'h2000, 8'd0, 3'd6);
      s_arvalid = 3'b010; m_arready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1; chk("t3_grant", s_arready, 3'b010);
         tick();
      end
      #1;
      chk("t3_ost1_full", cnt(1), 16);
      chk("t3_blocked", s_arready, 0);
      tick(); #1;
      chk("t3_blocked2", s_arready, 0);
      tick();
      m_rid = 4'h4; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 3'b010; #1;
      chk("t3_m_rready", m_rready, 1);
      chk("t3_blocked3", s_arready, 0);
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0; #1;
      chk("t3_ost1_dec", cnt(1), 15);
      chk("t3_17th", s_arready, 3'b010);
      tick();
      chk("t3_ost1_refull", cnt(1), 16);
      idle(); tick();

      // 4: backpressure holds m_ar*, then reg_arb_en gating
      do_reset();
      set_ar(0, 2'b01, 64'h1000, 8'd7, 3'd6);
      set_ar(1, 2'b10, 64'h3000, 8'd3, 3'd5);
      s_arvalid = 3'b001; m_arready = 1'b0; #1;
      chk("t4_first_grant", s_arready, 3'b001);
      tick();
      s_arvalid = 3'b011;
      set_ar(0, 2'b01, 64'h2000, 8'd7, 3'd6);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_hold_s_arready", s_arready, 0);
         chk("t4_hold_m_araddr", m_araddr, 64'h1000);
         chk("t4_hold_m_arid", m_arid, 4'h1);
         chk("t4_hold_m_arvalid", m_arvalid, 1);
         tick();
      end
      m_arready = 1'b1; #1;
      chk("t4_release_grant", s_arready, 3'b010);
      tick();
      chk("t4_m_araddr", m_araddr, 64'h3000);
      chk("t4_m_arid", m_arid, 4'h6);
      chk("t4_m_arlen", m_arlen, 3);
      reg_arb_en = 1'b0; m_arready = 1'b0; #1;
      chk("t4_en0_s_arready", s_arready, 0);
      tick();
      chk("t4_en0_hold", m_araddr, 64'h3000);
      m_arready = 1'b1; #1;
      chk("t4_en0_no_grant", s_arready, 0);
      tick();
      chk("t4_en0_drained", m_arvalid, 0);
      idle(); reg_arb_en = 1'b1; tick();

      // 5: RID index beyond REQ_NUM, sticky error and clear
      m_rid = 4'hC; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = '0; #1;
      chk("t5_m_rready", m_rready, 1);
      chk("t5_s_rvalid", s_rvalid, 0);
      tick();
      idle();
      chk("t5_err_set", reg_rsp_err, 1);
      chk("t5_ost_same", reg_ost_cnt, {5'd0, 5'd1, 5'd1});
      cnt_reg_clr = 1'b1; tick(); cnt_reg_clr = 1'b0;
      chk("t5_err_clr", reg_rsp_err, 0);
      m_rid = 4'hC; m_rvalid = 1'b1; cnt_reg_clr = 1'b1; tick();
      idle();
      chk("t5_set_wins", reg_rsp_err, 1);
      cnt_reg_clr = 1'b1; tick(); cnt_reg_clr = 1'b0;
      chk("t5_err_clr2", reg_rsp_err, 0);
      m_rid = 4'h8; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 3'b100; #1;
      chk("t5_zero_s_rvalid", s_rvalid, 3'b100);
      tick();
      idle();
      chk("t5_zero_ost2", cnt(2), 0);
      chk("t5_zero_err", reg_rsp_err, 1);

      // 6: simultaneous issue and completion, then reset mid-burst
      do_reset();
      set_ar(0, 2'b00, 64'h4000, 8'd1, 3'd6);
      s_arvalid = 3'b001; m_arready = 1'b1;
      tick(); tick(); tick();
      chk("t6_ost0_3", cnt(0), 3);
      m_rid = 4'h0; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 3'b001; #1;
      chk("t6_both_s_arready", s_arready, 3'b001);
      chk("t6_both_m_rready", m_rready, 1);
      tick();
      chk("t6_ost0_same", cnt(0), 3);
      s_arvalid = 3'b011; m_rid = 4'h1; m_rlast = 1'b0; s_rready = 3'b011;
      rst = 1'b1; #1;
      chk("t6_rst_s_arready", s_arready, 0);
      chk("t6_rst_s_rvalid", s_rvalid, 0);
      chk("t6_rst_m_rready", m_rready, 0);
      tick();
      chk("t6_rst_m_arvalid", m_arvalid, 0);
      chk("t6_rst_ost", reg_ost_cnt, 0);
      chk("t6_rst_s_arready2", s_arready, 0);
      rst = 1'b0; idle(); tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
